vga_write_arbiter: RTL and testbench

- Shares the single VGA framebuffer write port between the pixel-writing engines of circuit configuration: dashed node line, element wire, element sprite, top node and bottom node writers.
- Arbitration is round-robin across requesters, with an optional burst lock so a sprite can be drawn uninterrupted.
- Contains a screen-clear sweep engine, started by a level handshake, that owns the port while it runs.
- Sits between the configuration datapath and the VGA adapter's plot/x/y/colour inputs.

---
 rtl/vga_write_arbiter.sv | 174 +++++++++++++++++
 tb/tb_vga_write_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - round-robin framebuffer write-port arbiter with clear-screen sweep
module vga_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int COLOUR_W  = 3,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119,
    parameter int BG_COLOUR = 0,
    localparam int GW       = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         program_resetn,
    input  logic                         go_clear_screen,
    output logic                         clear_done,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           lock,
    input  logic [NUM_REQ*X_W-1:0]       req_x,
    input  logic [NUM_REQ*Y_W-1:0]       req_y,
    input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         vga_plot,
    output logic [X_W-1:0]               vga_x,
    output logic [Y_W-1:0]               vga_y,
    output logic [COLOUR_W-1:0]          vga_colour,
    output logic                         busy,
    output logic [GW-1:0]                grant_idx
);

    localparam logic [X_W-1:0]      X_LAST = X_W'(X_MAX);
    localparam logic [Y_W-1:0]      Y_LAST = Y_W'(Y_MAX);
    localparam logic [COLOUR_W-1:0] BG     = COLOUR_W'(BG_COLOUR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_CLEAR,
        S_CLEAR_DONE
    } state_t;

    state_t                state, state_d;
    logic [X_W-1:0]        cx, cx_d;
    logic [Y_W-1:0]        cy, cy_d;
    logic                  plot_d;
    logic                  done_d;
    logic                  busy_d;
    logic [X_W-1:0]        x_d;
    logic [Y_W-1:0]        y_d;
    logic [COLOUR_W-1:0]   colour_d;
    logic [NUM_REQ-1:0]    ack_d;
    logic [GW-1:0]         grant_d;

    logic                  win_found;
    logic [GW-1:0]         win_idx;
    int                    arb_j;

    // A locked last grantee keeps the port; otherwise search starts just after it.
    always_comb begin
        win_found = 1'b0;
        win_idx   = grant_idx;
        arb_j     = 0;
        if (lock[grant_idx] && req[grant_idx]) begin
            win_found = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                arb_j = int'(grant_idx) + k;
                if (arb_j >= NUM_REQ) begin
                    arb_j = arb_j - NUM_REQ;
                end
                if (!win_found && req[arb_j]) begin
                    win_found = 1'b1;
                    win_idx   = GW'(arb_j);
                end
            end
        end
    end

    always_comb begin
        state_d  = state;
        cx_d     = cx;
        cy_d     = cy;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        x_d      = vga_x;
        y_d      = vga_y;
        colour_d = vga_colour;
        ack_d    = '0;
        grant_d  = grant_idx;
        case (state)
            S_IDLE: begin
                if (go_clear_screen) begin
                    state_d  = S_CLEAR;
                    cx_d     = '0;
                    cy_d     = '0;
                    plot_d   = 1'b1;
                    x_d      = '0;
                    y_d      = '0;
                    colour_d = BG;
                end else if (win_found) begin
                    state_d          = S_WRITE;
                    plot_d           = 1'b1;
                    x_d              = req_x[win_idx*X_W +: X_W];
                    y_d              = req_y[win_idx*Y_W +: Y_W];
                    colour_d         = req_colour[win_idx*COLOUR_W +: COLOUR_W];
                    ack_d[win_idx]   = 1'b1;
                    grant_d          = win_idx;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_CLEAR: begin
                // cx/cy hold the pixel currently on the outputs
                if (cx == X_LAST && cy == Y_LAST) begin
                    state_d = S_CLEAR_DONE;
                    done_d  = 1'b1;
                end else begin
                    if (cx == X_LAST) begin
                        cx_d = '0;
                        cy_d = cy + Y_W'(1);
                    end else begin
                        cx_d = cx + X_W'(1);
                    end
                    plot_d   = 1'b1;
                    x_d      = cx_d;
                    y_d      = cy_d;
                    colour_d = BG;
                end
            end
            S_CLEAR_DONE: begin
                if (go_clear_screen) begin
                    done_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge program_resetn) begin
        if (!program_resetn) begin
            state      <= S_IDLE;
            cx         <= '0;
            cy         <= '0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            ack        <= '0;
            clear_done <= 1'b0;
            busy       <= 1'b0;
            grant_idx  <= GW'(NUM_REQ - 1);
        end else begin
            state      <= state_d;
            cx         <= cx_d;
            cy         <= cy_d;
            vga_plot   <= plot_d;
            vga_x      <= x_d;
            vga_y      <= y_d;
            vga_colour <= colour_d;
            ack        <= ack_d;
            clear_done <= done_d;
            busy       <= busy_d;
            grant_idx  <= grant_d;
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// tb/tb_vga_write_arbiter.sv - self-checking bench for vga_write_arbiter
module tb_vga_write_arbiter;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        program_resetn;
    logic        go_clear_screen;
    logic        clear_done;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] req_x;
    logic [27:0] req_y;
    logic [11:0] req_colour;
    logic [3:0]  ack;
    logic        vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        busy;
    logic [1:0]  grant_idx;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vga_write_arbiter dut (
        .clk             (clk),
        .program_resetn  (program_resetn),
        .go_clear_screen (go_clear_screen),
        .clear_done      (clear_done),
        .req             (req),
        .lock            (lock),
        .req_x           (req_x),
        .req_y           (req_y),
        .req_colour      (req_colour),
        .ack             (ack),
        .vga_plot        (vga_plot),
        .vga_x           (vga_x),
        .vga_y           (vga_y),
        .vga_colour      (vga_colour),
        .busy            (busy),
        .grant_idx       (grant_idx)
    );

    typedef struct {
        logic [3:0] rq;
        logic [3:0] lk;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic [3:0] eack;
        logic [1:0] egrant;
    } vec_t;

    vec_t vt[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        program_resetn  = 1'b0;
        go_clear_screen = 1'b0;
        req             = '0;
        lock            = '0;
        req_x           = '0;
        req_y           = '0;
        req_colour      = '0;
        repeat (2) @(negedge clk);
        program_resetn  = 1'b1;
    endtask

    function automatic logic [7:0] slot_x(input logic [7:0] x, input int i);
        return x + 8'(i * 16);
    endfunction
    function automatic logic [6:0] slot_y(input logic [6:0] y, input int i);
        return y + 7'(i * 8);
    endfunction
    function automatic logic [2:0] slot_c(input logic [2:0] c, input int i);
        return c ^ 3'(i);
    endfunction

    initial begin
        int          wait_cnt;
        int          bad;
        int          got_n;
        logic [3:0]  got[4];
        logic [3:0]  exp_ack;
        // random-test reference state
        int          last_g;
        bit          in_write;
        bit          e_plot;
        logic [3:0]  e_ack;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [2:0]  e_c;
        bit          pend[4];
        logic [7:0]  dx[4];
        logic [6:0]  dy[4];
        logic [2:0]  dc[4];
        int          w;

        vt[0]  = '{4'b0001, 4'b0000, 8'd10,  7'd20,  3'd5, 4'b0001, 2'd0};
        vt[1]  = '{4'b1111, 4'b0000, 8'd1,   7'd2,   3'd1, 4'b0010, 2'd1};
        vt[2]  = '{4'b1111, 4'b0000, 8'd33,  7'd44,  3'd2, 4'b0100, 2'd2};
        vt[3]  = '{4'b1111, 4'b0100, 8'd50,  7'd60,  3'd3, 4'b0100, 2'd2};
        vt[4]  = '{4'b1011, 4'b0100, 8'd70,  7'd80,  3'd4, 4'b1000, 2'd3};
        vt[5]  = '{4'b0011, 4'b1000, 8'd90,  7'd100, 3'd6, 4'b0001, 2'd0};
        vt[6]  = '{4'b0110, 4'b0100, 8'd5,   7'd6,   3'd7, 4'b0010, 2'd1};
        vt[7]  = '{4'b0001, 4'b0000, 8'd0,   7'd0,   3'd0, 4'b0001, 2'd0};
        vt[8]  = '{4'b0000, 4'b1111, 8'd12,  7'd13,  3'd1, 4'b0000, 2'd0};
        vt[9]  = '{4'b1000, 4'b0000, 8'd159, 7'd119, 3'd7, 4'b1000, 2'd3};
        vt[10] = '{4'b1001, 4'b1000, 8'd20,  7'd30,  3'd2, 4'b1000, 2'd3};
        vt[11] = '{4'b1001, 4'b0000, 8'd21,  7'd31,  3'd5, 4'b0001, 2'd0};

        // ---- reset state ----
        program_resetn = 1'b0;
        go_clear_screen = 1'b0;
        req = '0; lock = '0; req_x = '0; req_y = '0; req_colour = '0;
        @(negedge clk);
        check("rst_plot", vga_plot, 0);
        check("rst_ack", ack, 0);
        check("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
        check("rst_busy_done", {busy, clear_done}, 0);
        check("rst_grant", grant_idx, 3);
        do_reset();

        // ---- table-driven single writes ----
        for (int v = 0; v < 12; v++) begin
            req  = vt[v].rq;
            lock = vt[v].lk;
            for (int i = 0; i < N; i++) begin
                req_x[i*8 +: 8]      = slot_x(vt[v].x, i);
                req_y[i*7 +: 7]      = slot_y(vt[v].y, i);
                req_colour[i*3 +: 3] = slot_c(vt[v].c, i);
            end
            @(negedge clk);
            check($sformatf("vec%0d_ack", v), ack, vt[v].eack);
            check($sformatf("vec%0d_plot", v), vga_plot, (vt[v].eack != 0));
            check($sformatf("vec%0d_grant", v), grant_idx, vt[v].egrant);
            if (vt[v].eack != 0) begin
                check($sformatf("vec%0d_x", v), vga_x, slot_x(vt[v].x, int'(vt[v].egrant)));
                check($sformatf("vec%0d_y", v), vga_y, slot_y(vt[v].y, int'(vt[v].egrant)));
                check($sformatf("vec%0d_c", v), vga_colour, slot_c(vt[v].c, int'(vt[v].egrant)));
                check($sformatf("vec%0d_busy", v), busy, 1);
            end
            req = '0;
            @(negedge clk);
            check($sformatf("vec%0d_after_plot", v), vga_plot, 0);
            check($sformatf("vec%0d_after_ack", v), ack, 0);
        end

        // ---- all requesters held: rotation, one ack per 2 cycles ----
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            exp_ack = (k % 2 == 1) ? 4'b0000 : 4'(1 << ((k / 2) % 4));
            check($sformatf("rot%0d_ack", k), ack, exp_ack);
        end
        req = '0;

        // ---- burst lock on requester 0 ----
        do_reset();
        req  = 4'b0101;
        lock = 4'b0001;
        got_n = 0;
        for (int i = 0; i < 4; i++) got[i] = '0;
        for (int k = 0; k < 30 && got_n < 4; k++) begin
            @(negedge clk);
            if (ack != 0) begin
                got[got_n] = ack;
                got_n++;
                if (got_n == 3) lock = '0;
            end
        end
        check("lock_ack_count", got_n, 4);
        check("lock_ack0", got[0], 4'b0001);
        check("lock_ack1", got[1], 4'b0001);
        check("lock_ack2", got[2], 4'b0001);
        check("lock_ack3", got[3], 4'b0100);
        req = '0;

        // ---- full clear sweep with a pending request ----
        do_reset();
        go_clear_screen = 1'b1;
        req = 4'b0010;
        for (int i = 0; i < N; i++) begin
            req_x[i*8 +: 8] = 8'(40 + i); req_y[i*7 +: 7] = 7'(50 + i); req_colour[i*3 +: 3] = 3'(i + 1);
        end
        wait_cnt = 0;
        @(negedge clk);
        while (!vga_plot && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("clr_start_plot", vga_plot, 1);
        check("clr_busy", busy, 1);
        bad = 0;
        for (int n = 0; n < 19200; n++) begin
            if (n > 0) @(negedge clk);
            if (vga_plot !== 1'b1 || vga_x !== 8'(n % 160) || vga_y !== 7'(n / 160) ||
                vga_colour !== 3'd0 || ack !== 4'b0 || clear_done !== 1'b0) bad++;
            if (n == 0)     check("clr_first", {vga_x, vga_y}, {8'd0, 7'd0});
            if (n == 159)   check("clr_row0_end", {vga_x, vga_y}, {8'd159, 7'd0});
            if (n == 160)   check("clr_row1_start", {vga_x, vga_y}, {8'd0, 7'd1});
            if (n == 19199) check("clr_last", {vga_x, vga_y}, {8'd159, 7'd119});
        end
        check("clr_bad_pixels", bad, 0);
        @(negedge clk);
        check("clr_done_plot", vga_plot, 0);
        check("clr_done_flag", clear_done, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("clr_hold%0d", k), {clear_done, busy, ack}, {1'b1, 1'b1, 4'b0});
        end
        go_clear_screen = 1'b0;
        @(negedge clk);
        check("clr_exit_done", clear_done, 0);
        check("clr_exit_busy", busy, 0);
        check("clr_exit_ack", ack, 0);
        @(negedge clk);
        check("clr_pend_ack", ack, 4'b0010);
        check("clr_pend_xy", {vga_plot, vga_x, vga_y, vga_colour}, {1'b1, 8'd41, 7'd51, 3'd2});
        req = '0;

        // ---- reset in the middle of a sweep ----
        do_reset();
        go_clear_screen = 1'b1;
        wait_cnt = 0;
        @(negedge clk);
        while (!(vga_plot && vga_x == 8'd37 && vga_y == 7'd5) && wait_cnt < 1500) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("mid_reached", {vga_x, vga_y}, {8'd37, 7'd5});
        #1 program_resetn = 1'b0;
        #1;
        check("mid_rst_out", {vga_plot, vga_x, vga_y, vga_colour, busy, clear_done, ack}, 0);
        check("mid_rst_grant", grant_idx, 3);
        @(negedge clk);
        program_resetn = 1'b1;
        wait_cnt = 0;
        @(negedge clk);
        while (!vga_plot && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("mid_restart", {vga_plot, vga_x, vga_y}, {1'b1, 8'd0, 7'd0});

        // ---- randomized traffic against a transaction-level model ----
        do_reset();
        last_g = N - 1;
        in_write = 0;
        e_ack = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0; dx[i] = '0; dy[i] = '0; dc[i] = '0;
        end
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (e_ack[i] || (!pend[i] && $urandom_range(2, 0) == 0)) begin
                    pend[i] = e_ack[i] ? ($urandom_range(1, 0) == 1) : 1'b1;
                    dx[i] = 8'($urandom_range(159, 0));
                    dy[i] = 7'($urandom_range(119, 0));
                    dc[i] = 3'($urandom_range(7, 0));
                end
            end
            lock = ($urandom_range(1, 0) == 1) ? 4'($urandom_range(15, 0)) : 4'b0;
            for (int i = 0; i < N; i++) begin
                req[i]               = pend[i];
                req_x[i*8 +: 8]      = dx[i];
                req_y[i*7 +: 7]      = dy[i];
                req_colour[i*3 +: 3] = dc[i];
            end
            // a written pixel occupies the port for two cycles
            e_ack = '0;
            e_plot = 0;
            if (in_write) begin
                in_write = 0;
            end else begin
                w = -1;
                if (lock[last_g] && pend[last_g]) w = last_g;
                else
                    for (int k = 1; k <= N; k++)
                        if (w < 0 && pend[(last_g + k) % N]) w = (last_g + k) % N;
                if (w >= 0) begin
                    e_plot = 1; e_ack[w] = 1'b1; last_g = w; in_write = 1;
                    e_x = dx[w]; e_y = dy[w]; e_c = dc[w];
                end
            end
            @(negedge clk);
            check("rnd_plot", vga_plot, e_plot);
            check("rnd_ack", ack, e_ack);
            check("rnd_grant", grant_idx, last_g);
            if (e_plot) check("rnd_xyc", {vga_x, vga_y, vga_colour}, {e_x, e_y, e_c});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
